// File: rtl/startfill_sprite_drawer.sv
// Sprite pixel stage around the "start" fill-shape ROM: box addressing, a two-clock colour
// pipeline, and a per-frame fill/drain animation driven by the hold input.
module startfill_sprite_drawer #(
  parameter int unsigned X0          = 28,
  parameter int unsigned Y0          = 150,
  parameter int unsigned WIDTH       = 584,
  parameter int unsigned HEIGHT      = 167,
  parameter int unsigned FILL_STEP   = 8,
  parameter int unsigned DRAIN_STEP  = 16,
  parameter logic [11:0] FILL_COLOR  = 12'h0F0,
  parameter logic [11:0] EMPTY_COLOR = 12'h444
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        video_on,
  input  logic        frame_tick,
  input  logic        hold,
  input  logic [11:0] bg_rgb,
  output logic [7:0]  rom_row,
  output logic [9:0]  rom_col,
  input  logic [11:0] rom_color,
  output logic [11:0] rgb_out,
  output logic [9:0]  fill_level,
  output logic        fill_done
);

  typedef enum logic [1:0] {IDLE, FILLING, FULL, DRAINING} state_e;

  localparam logic [9:0] X_LO  = 10'(X0);
  localparam logic [9:0] X_HI  = 10'(X0 + WIDTH);
  localparam logic [9:0] Y_LO  = 10'(Y0);
  localparam logic [9:0] Y_HI  = 10'(Y0 + HEIGHT);
  localparam logic [9:0] W_MAX = 10'(WIDTH);
  localparam logic [9:0] F_ST  = 10'(FILL_STEP);
  localparam logic [9:0] D_ST  = 10'(DRAIN_STEP);

  logic        in_box;
  logic        in_box_q, video_on_q;
  logic [9:0]  col_q;
  logic [11:0] bg_q;
  logic [11:0] rgb_q, rgb_d;
  state_e      state_q, state_d;
  logic [9:0]  fill_q, fill_d;
  logic        done_q, done_d;
  logic [10:0] fill_sum;
  logic [9:0]  fill_inc, fill_dec;

  assign in_box = (hcount >= X_LO) && (hcount < X_HI) && (vcount >= Y_LO) && (vcount < Y_HI);

  always_comb begin
    rom_row = '0;
    rom_col = '0;
    if (in_box) begin
      rom_col = hcount - X_LO;
      rom_row = 8'(vcount - Y_LO);
    end
  end

  // Stage 1 lines up with the ROM's registered output; stage 2 picks the final colour.
  always_comb begin
    rgb_d = bg_q;
    if (!video_on_q)
      rgb_d = '0;
    else if (in_box_q && rom_color == 12'hFFF)
      rgb_d = (col_q < fill_q) ? FILL_COLOR : EMPTY_COLOR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_box_q   <= 1'b0;
      video_on_q <= 1'b0;
      col_q      <= '0;
      bg_q       <= '0;
      rgb_q      <= '0;
    end else begin
      in_box_q   <= in_box;
      video_on_q <= video_on;
      col_q      <= rom_col;
      bg_q       <= bg_rgb;
      rgb_q      <= rgb_d;
    end
  end

  assign fill_sum = {1'b0, fill_q} + {1'b0, F_ST};
  assign fill_inc = (fill_sum >= {1'b0, W_MAX}) ? W_MAX : fill_sum[9:0];
  assign fill_dec = (fill_q <= D_ST) ? '0 : fill_q - D_ST;

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    done_d  = 1'b0;
    if (frame_tick) begin
      case (state_q)
        IDLE: begin
          if (hold) begin
            state_d = FILLING;
            fill_d  = fill_inc;
          end
        end
        FILLING: begin
          if (hold) begin
            fill_d = fill_inc;
            if (fill_inc == W_MAX) begin
              state_d = FULL;
              done_d  = 1'b1;
            end
          end else begin
            fill_d  = fill_dec;
            state_d = (fill_dec == '0) ? IDLE : DRAINING;
          end
        end
        FULL: begin
          if (!hold) begin
            fill_d  = fill_dec;
            state_d = (fill_dec == '0) ? IDLE : DRAINING;
          end
        end
        DRAINING: begin
          if (hold) begin
            state_d = FILLING;
            fill_d  = fill_inc;
          end else begin
            fill_d  = fill_dec;
            state_d = (fill_dec == '0) ? IDLE : DRAINING;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fill_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      done_q  <= done_d;
    end
  end

  assign rgb_out    = rgb_q;
  assign fill_level = fill_q;
  assign fill_done  = done_q;

endmodule

// File: tb/tb_startfill_sprite_drawer.sv
// Bench for startfill_sprite_drawer: directed scenarios plus a randomized pixel/tick stream
// checked against a frame-level animation model and a geometric pixel model.
module tb_startfill_sprite_drawer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  hcount, vcount;
  logic        video_on, frame_tick, hold;
  logic [11:0] bg_rgb;
  logic [7:0]  rom_row;
  logic [9:0]  rom_col;
  logic [11:0] rom_color;
  logic [11:0] rgb_out;
  logic [9:0]  fill_level;
  logic        fill_done;

  int n_checks = 0;
  int n_fail   = 0;
  int rom_mode = 0;   // 0: patterned shape, 1: all 12'hFFF, 2: all 12'h000

  typedef enum {M_IDLE, M_FILLING, M_FULL, M_DRAINING} mstate_t;
  mstate_t m_state = M_IDLE;
  int      m_fill  = 0;
  bit      m_done  = 1'b0;

  startfill_sprite_drawer #(
    .X0(28), .Y0(150), .WIDTH(584), .HEIGHT(167),
    .FILL_STEP(8), .DRAIN_STEP(16),
    .FILL_COLOR(12'h0F0), .EMPTY_COLOR(12'h444)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
    .video_on(video_on), .frame_tick(frame_tick), .hold(hold), .bg_rgb(bg_rgb),
    .rom_row(rom_row), .rom_col(rom_col), .rom_color(rom_color),
    .rgb_out(rgb_out), .fill_level(fill_level), .fill_done(fill_done)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] shape(int r, int c);
    case ((r * 7 + c * 3) % 5)
      0, 1, 2: return 12'hFFF;
      3:       return 12'h000;
      default: return 12'hFFE;
    endcase
  endfunction

  function automatic logic [11:0] rom_lookup(int r, int c);
    if (rom_mode == 1) return 12'hFFF;
    if (rom_mode == 2) return 12'h000;
    return shape(r, c);
  endfunction

  // Registered ROM stub: one clock of read latency.
  always @(posedge clk) rom_color <= rom_lookup(int'(rom_row), int'(rom_col));

  function automatic logic [11:0] exp_pix(int h, int v, bit von, logic [11:0] bg, int fill);
    if (!von) return 12'h000;
    if (h >= 28 && h < 612 && v >= 150 && v < 317) begin
      if (rom_lookup(v - 150, h - 28) == 12'hFFF)
        return (h - 28 < fill) ? 12'h0F0 : 12'h444;
    end
    return bg;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_fill  = 0;
    m_done  = 1'b0;
  endtask

  task automatic model_tick(input bit h);
    m_done = 1'b0;
    if ((m_state == M_IDLE || m_state == M_FILLING || m_state == M_DRAINING) && h) begin
      m_fill = (m_fill + 8 > 584) ? 584 : m_fill + 8;
      if (m_state == M_FILLING && m_fill == 584) begin
        m_state = M_FULL;
        m_done  = 1'b1;
      end else begin
        m_state = M_FILLING;
      end
    end else if (m_state != M_IDLE && !h) begin
      m_fill  = (m_fill <= 16) ? 0 : m_fill - 16;
      m_state = (m_fill == 0) ? M_IDLE : M_DRAINING;
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clk1();
    frame_tick = 1'b0;
    hold       = 1'b0;
    rst_n      = 1'b0;
    #2;
    rst_n      = 1'b1;
    model_reset();
  endtask

  task automatic do_tick(input bit h);
    hold       = h;
    frame_tick = 1'b1;
    clk1();
    frame_tick = 1'b0;
    model_tick(h);
  endtask

  task automatic test_reset();
    video_on = 1'b1; hcount = 10'd50; vcount = 10'd160; bg_rgb = 12'hABC;
    rom_mode = 0;
    clk1(); clk1();
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) do_tick(1'b1);
    clk1();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rgb_out !== 12'h000) begin n_fail++; $display("FAIL reset_rgb: got %h expected 000", rgb_out); end
    n_checks++;
    if (fill_level !== 10'd0) begin n_fail++; $display("FAIL reset_fill: got %0d expected 0", fill_level); end
    n_checks++;
    if (fill_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", fill_done); end
    #1;
    rst_n = 1'b1;
    model_reset();
    hcount = 10'd27; vcount = 10'd150; bg_rgb = 12'h5A5;
    #1;
    n_checks++;
    if (rom_row !== 8'd0 || rom_col !== 10'd0) begin
      n_fail++; $display("FAIL reset_addr_outside: got row %0d col %0d expected 0 0", rom_row, rom_col);
    end
    clk1(); clk1();
    n_checks++;
    if (rgb_out !== 12'h5A5) begin n_fail++; $display("FAIL reset_bg_after: got %h expected 5a5", rgb_out); end
  endtask

  task automatic test_addressing();
    do_reset();
    rom_mode = 1; video_on = 1'b1; bg_rgb = 12'h123;
    hcount = 10'd28; vcount = 10'd150; #1;
    n_checks++;
    if (rom_row !== 8'd0 || rom_col !== 10'd0) begin
      n_fail++; $display("FAIL addr_origin: got row %0d col %0d expected 0 0", rom_row, rom_col);
    end
    hcount = 10'd611; vcount = 10'd316; #1;
    n_checks++;
    if (rom_row !== 8'd166 || rom_col !== 10'd583) begin
      n_fail++; $display("FAIL addr_corner: got row %0d col %0d expected 166 583", rom_row, rom_col);
    end
    hcount = 10'd612; #1;
    n_checks++;
    if (rom_row !== 8'd0 || rom_col !== 10'd0) begin
      n_fail++; $display("FAIL addr_right_edge: got row %0d col %0d expected 0 0", rom_row, rom_col);
    end
    clk1(); clk1();
    n_checks++;
    if (rgb_out !== 12'h123) begin n_fail++; $display("FAIL lat_pre: got %h expected 123", rgb_out); end
    hcount = 10'd100; vcount = 10'd200; bg_rgb = 12'h456;
    clk1();
    n_checks++;
    if (rgb_out !== 12'h123) begin n_fail++; $display("FAIL lat_one_clock: got %h expected 123", rgb_out); end
    clk1();
    n_checks++;
    if (rgb_out !== 12'h444) begin n_fail++; $display("FAIL lat_two_clock: got %h expected 444", rgb_out); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int k = 1; k <= 73; k++) begin
      do_tick(1'b1);
      n_checks++;
      if (fill_level !== 10'(8 * k) || fill_level !== 10'(m_fill)) begin
        n_fail++; $display("FAIL fill_ramp: tick %0d got %0d expected %0d", k, fill_level, 8 * k);
      end
      n_checks++;
      if (fill_done !== (k == 73)) begin
        n_fail++; $display("FAIL fill_done_pulse: tick %0d got %b expected %b", k, fill_done, k == 73);
      end
    end
    clk1();
    n_checks++;
    if (fill_done !== 1'b0) begin n_fail++; $display("FAIL fill_done_width: got %b expected 0", fill_done); end
    for (int k = 0; k < 3; k++) begin
      do_tick(1'b1);
      n_checks++;
      if (fill_level !== 10'd584 || fill_done !== 1'b0) begin
        n_fail++; $display("FAIL full_hold: got level %0d done %b expected 584 0", fill_level, fill_done);
      end
    end
    do_tick(1'b0);
    n_checks++;
    if (fill_level !== 10'(m_fill) || fill_level !== 10'd568) begin
      n_fail++; $display("FAIL full_release: got %0d expected 568", fill_level);
    end
  endtask

  task automatic test_fill_colour();
    logic [9:0]  h_t [4] = '{10'd43, 10'd44, 10'd43, 10'd43};
    int          m_t [4] = '{1, 1, 2, 1};
    bit          v_t [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [11:0] e_t [4] = '{12'h0F0, 12'h444, 12'hABC, 12'h000};
    do_reset();
    do_tick(1'b1);
    do_tick(1'b1);
    n_checks++;
    if (fill_level !== 10'd16) begin n_fail++; $display("FAIL colour_setup: got %0d expected 16", fill_level); end
    for (int i = 0; i < 4; i++) begin
      rom_mode = m_t[i]; video_on = v_t[i]; hcount = h_t[i]; vcount = 10'd160; bg_rgb = 12'hABC;
      clk1(); clk1();
      n_checks++;
      if (rgb_out !== e_t[i]) begin
        n_fail++; $display("FAIL colour_case%0d: got %h expected %h", i, rgb_out, e_t[i]);
      end
    end
    rom_mode = 0;
  endtask

  task automatic test_drain_reverse();
    int drain_exp [5] = '{24, 8, 0, 0, 8};
    bit drain_h   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int rev_exp   [3] = '{24, 32, 40};
    bit rev_h     [3] = '{1'b0, 1'b1, 1'b1};
    do_reset();
    for (int k = 0; k < 5; k++) do_tick(1'b1);
    n_checks++;
    if (fill_level !== 10'd40) begin n_fail++; $display("FAIL drain_setup: got %0d expected 40", fill_level); end
    for (int i = 0; i < 5; i++) begin
      do_tick(drain_h[i]);
      n_checks++;
      if (fill_level !== 10'(drain_exp[i]) || fill_level !== 10'(m_fill)) begin
        n_fail++; $display("FAIL drain_step%0d: got %0d expected %0d", i, fill_level, drain_exp[i]);
      end
    end
    do_reset();
    for (int k = 0; k < 5; k++) do_tick(1'b1);
    for (int i = 0; i < 3; i++) begin
      do_tick(rev_h[i]);
      n_checks++;
      if (fill_level !== 10'(rev_exp[i]) || fill_done !== 1'b0) begin
        n_fail++; $display("FAIL reverse_step%0d: got %0d done %b expected %0d 0", i, fill_level, fill_done, rev_exp[i]);
      end
    end
  endtask

  task automatic test_tick_gating();
    do_reset();
    for (int r = 0; r < 4; r++) begin
      hold = 1'b1; clk1();
      hold = 1'b0; clk1();
      hold = 1'b1; clk1();
      do_tick(1'b0);
      n_checks++;
      if (fill_level !== 10'd0 || fill_done !== 1'b0) begin
        n_fail++; $display("FAIL gating_idle%0d: got %0d done %b expected 0 0", r, fill_level, fill_done);
      end
    end
    do_tick(1'b1);
    n_checks++;
    if (fill_level !== 10'd8) begin n_fail++; $display("FAIL gating_start: got %0d expected 8", fill_level); end
    hold = 1'b0; clk1(); clk1();
    do_tick(1'b1);
    n_checks++;
    if (fill_level !== 10'd16) begin n_fail++; $display("FAIL gating_filling: got %0d expected 16", fill_level); end
  endtask

  task automatic test_random_stream();
    logic [11:0] exp_prev = '0;
    bit          have_prev = 1'b0;
    int          h, v;
    bit          von, tk, hh;
    logic [11:0] bg;
    rom_mode = 0;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      h   = $urandom_range(0, 700);
      v   = $urandom_range(120, 340);
      von = ($urandom % 8) != 0;
      bg  = 12'($urandom);
      tk  = ($urandom % 6) == 0;
      hh  = ($urandom % 4) != 0;
      hcount = 10'(h); vcount = 10'(v); video_on = von; bg_rgb = bg;
      frame_tick = tk; hold = hh;
      clk1();
      if (tk) model_tick(hh);
      else m_done = 1'b0;
      if (have_prev) begin
        n_checks++;
        if (rgb_out !== exp_prev) begin
          n_fail++; $display("FAIL rand_pixel: cycle %0d got %h expected %h", i, rgb_out, exp_prev);
        end
      end
      n_checks++;
      if (fill_level !== 10'(m_fill)) begin
        n_fail++; $display("FAIL rand_fill: cycle %0d got %0d expected %0d", i, fill_level, m_fill);
      end
      n_checks++;
      if (fill_done !== m_done) begin
        n_fail++; $display("FAIL rand_done: cycle %0d got %b expected %b", i, fill_done, m_done);
      end
      exp_prev  = exp_pix(h, v, von, bg, m_fill);
      have_prev = 1'b1;
    end
    frame_tick = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; hcount = '0; vcount = '0; video_on = 1'b0;
    frame_tick = 1'b0; hold = 1'b0; bg_rgb = '0;
    test_reset();
    test_addressing();
    test_fill();
    test_fill_colour();
    test_drain_reverse();
    test_tick_gating();
    test_random_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/startfill_sprite_drawer.md
Name: startfill_sprite_drawer

Overview:
- Pixel-pipeline stage directly upstream and downstream of the 584x167 "start" fill-shape ROM.
- Maps VGA scan position (hcount/vcount) to ROM row/col inside a placed sprite box, then consumes the ROM's 1-cycle-registered colour.
- Applies a left-to-right fill animation, controlled by a hold input and advanced once per frame, and emits final 12-bit RGB.
- Sits between the VGA timing generator and the RGB output mux.

Parameters:
- X0, 28, left screen column of sprite box
- Y0, 150, top screen row of sprite box
- WIDTH, 584, sprite width in pixels (ROM row pitch)
- HEIGHT, 167, sprite height in rows
- FILL_STEP, 8, fill_level increment per frame while filling
- DRAIN_STEP, 16, fill_level decrement per frame while draining
- FILL_COLOR, 12'h0F0, colour of filled shape pixels
- EMPTY_COLOR, 12'h444, colour of unfilled shape pixels

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- hcount  in  10  current scan column
- vcount  in  10  current scan row
- video_on  in  1  active-display flag, aligned with hcount/vcount
- frame_tick  in  1  one-cycle pulse per frame (start of vblank)
- hold  in  1  start button held (already debounced/synchronised)
- bg_rgb  in  12  background colour, aligned with hcount/vcount
- rom_row  out  8  ROM row address (combinational)
- rom_col  out  10  ROM column address (combinational)
- rom_color  in  12  ROM data, valid 1 cycle after rom_row/rom_col
- rgb_out  out  12  final pixel colour
- fill_level  out  10  current fill width in pixels, 0..WIDTH
- fill_done  out  1  one-cycle pulse on entering FULL

Behaviour:
- Reset (async, rst_n=0):
  - rgb_out=0, fill_level=0, fill_done=0, state=IDLE.
  - All pipeline registers cleared.
  - Reset mid-fill discards progress.
- Address stage (combinational):
  - in_box = (hcount >= X0) && (hcount < X0+WIDTH) && (vcount >= Y0) && (vcount < Y0+HEIGHT).
  - When in_box: rom_col = hcount-X0, rom_row = vcount-Y0 (truncated to 8 bits).
  - When not in_box: rom_row=0, rom_col=0.
- Stage 1 registers (aligned with rom_color): in_box_d, col_d, video_on_d, bg_d.
- Stage 2 (registered rgb_out), priority order:
  - !video_on_d -> 0.
  - Else in_box_d && rom_color==12'hFFF -> (col_d < fill_level ? FILL_COLOR : EMPTY_COLOR).
  - Else -> bg_d.
- Total latency from hcount/vcount to rgb_out is exactly 2 clocks.
- fill_level is read in stage 2 and changes only on frame_tick, so there is no mid-frame tearing.
- FSM: states IDLE, FILLING, FULL, DRAINING. State and fill_level change only on cycles with frame_tick=1, using hold sampled that same cycle.
  - IDLE: hold -> FILLING; fill_level += FILL_STEP (saturate at WIDTH).
  - FILLING, hold=1: fill_level = min(fill_level+FILL_STEP, WIDTH). When the result equals WIDTH -> FULL, and fill_done=1 for that single cycle.
  - FILLING, hold=0: -> DRAINING, applying the drain step on the same tick.
  - FULL: hold=1 stays FULL. hold=0 -> DRAINING, with the first decrement on that tick.
  - DRAINING, hold=0: fill_level = (fill_level <= DRAIN_STEP) ? 0 : fill_level-DRAIN_STEP. Reaching 0 -> IDLE.
  - DRAINING, hold=1: -> FILLING, with the increment applied on the same tick.
- Arithmetic: 11-bit intermediate sum for saturation; no wrap past WIDTH, no underflow below 0.
- fill_done pulses only on the FILLING->FULL transition; it never re-pulses while in FULL.
- hold toggling between frame_ticks has no effect; only the value at the tick counts.
- frame_tick coincident with in-box pixels is legal; the new fill_level takes effect on the next cycle.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> rgb_out=0, fill_level=0, fill_done=0 immediately (async). Release, then drive hcount=27,vcount=150 -> rom_row=0,rom_col=0, and 2 clocks later rgb_out=bg_rgb.
- Addressing/latency: hcount=28,vcount=150 -> rom_row=0,rom_col=0. hcount=611,vcount=316 -> rom_row=166,rom_col=583. hcount=612 -> rom_col=0. Stub ROM returns FFF with fill_level=0 -> rgb_out=12'h444 exactly 2 clocks later.
- Fill: hold=1 for 73 frame_ticks -> fill_level 8,16,...,584, state FULL on tick 73, fill_done high exactly 1 cycle. Further ticks -> fill_level stays 584, no fill_done.
- Fill colouring: fill_level=16, shape pixel at hcount=28+15 -> 12'h0F0; at hcount=28+16 -> 12'h444. Non-shape ROM pixel (000) -> bg_rgb. video_on=0 -> 0.
- Drain/reversal: from fill_level=40 release hold -> 24, 8, then 0 and IDLE on the 3rd tick. Re-press hold at fill_level=24 in DRAINING -> next tick 32, state FILLING.
- Tick gating: toggle hold several times between frame_ticks with hold=0 at the tick -> no state change from IDLE, fill_level stays 0.
